npu_sram_stream_reader: RTL and testbench

- Read-side streamer for the NPU's 16-bit x 4096 dual-port on-chip SRAM buffers; drives the buffer's second (fabric-side) port.
- Accepts a (base, length) command and fetches consecutive words, accounting for the SRAM's 1-cycle read latency (registered address, unregistered q).
- Presents the words as a valid/ready stream with last-flag to the downstream MAC/activation pipeline.
- Absorbs backpressure with a small internal FIFO so no fetched word is lost.

---
 rtl/npu_stream_pkg.sv | 19 +
 rtl/npu_stream_fifo.sv | 56 +++++
 rtl/npu_sram_stream_reader.sv | 150 +++++++++++++++
 tb/tb_npu_sram_stream_reader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/npu_stream_pkg.sv
// Shared types and widths for the NPU SRAM stream reader.
package npu_stream_pkg;

  localparam int SRAM_ADDR_W = 12;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } stream_state_t;

  typedef struct packed {
    logic [SRAM_DATA_W-1:0] data;
    logic                   last;
  } stream_word_t;

endpackage

// File: rtl/npu_stream_fifo.sv
// Small synchronous FIFO holding fetched stream words until the consumer takes them.
module npu_stream_fifo
  import npu_stream_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(stream_word_t),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  // A pop frees the slot the same cycle, so push at full is allowed alongside it.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/npu_sram_stream_reader.sv
// Streams (base, len) word runs out of an NPU SRAM buffer with 1-cycle read latency.
// Optional NPU_STREAM_CHECKSUM_EN adds a running sum of accepted words.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// FETCH | issuing SRAM reads while FIFO space allows
// DRAIN | all reads issued, waiting for the last word to be accepted
// DONE  | one-cycle done pulse
module npu_sram_stream_reader
  import npu_stream_pkg::*;
#(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int LEN_W      = 13,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              abort,
  output logic [ADDR_W-1:0] sram_address,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [1:0]        sram_byteenable,
  output logic              sram_clken,
  input  logic [DATA_W-1:0] sram_readdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef NPU_STREAM_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  stream_state_t     state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q, issued_q;
  logic              inflight_q, inflight_last_q, started_q;
  logic              cmd_fire, issue, issue_last, pop, push;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  logic              fifo_full, fifo_empty;
  stream_word_t      push_word, head_word;

  assign sram_write      = 1'b0;
  assign sram_byteenable = 2'b11;
  assign sram_clken      = 1'b1;
  assign sram_address    = addr_q;
  assign sram_chipselect = issue;

  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign issue_last = (issued_q == len_q - 1'b1);
  // Words already in the FIFO plus the one still coming back from the SRAM.
  assign occupancy  = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q);

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : head_word.data;
  assign out_last  = fifo_empty ? 1'b0 : head_word.last;
  assign pop       = out_valid && out_ready;
  assign push      = inflight_q && !abort;
  assign push_word = '{data: sram_readdata, last: inflight_last_q};

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    cmd_ready = (state_q == IDLE) && started_q;
    cmd_fire  = cmd_ready && cmd_valid && !abort;
    case (state_q)
      IDLE:  if (cmd_fire) state_d = (cmd_len == '0) ? DONE : FETCH;
      FETCH: begin
        if (!fifo_full && occupancy < (CNT_W+1)'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: if (pop && head_word.last) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      issue   = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      started_q       <= 1'b0;
    end else begin
      started_q       <= 1'b1;
      state_q         <= state_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && issue_last;
      if (cmd_fire) begin
        addr_q   <= cmd_base;
        len_q    <= cmd_len;
        issued_q <= '0;
      end else if (issue) begin
        addr_q   <= addr_q + 1'b1;
        issued_q <= issued_q + 1'b1;
      end
    end
  end

  npu_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(stream_word_t)),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (abort),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (head_word),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef NPU_STREAM_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     checksum_q <= '0;
    else if (cmd_fire) checksum_q <= '0;
    else if (pop)     checksum_q <= checksum_q + out_data;
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_npu_sram_stream_reader.sv
// Directed bench for npu_sram_stream_reader with a behavioural 1-cycle-latency SRAM.
module tb_npu_sram_stream_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, abort;
  logic [11:0] cmd_base;
  logic [12:0] cmd_len;
  logic [11:0] sram_address;
  logic        sram_chipselect, sram_write, sram_clken;
  logic [1:0]  sram_byteenable;
  logic [15:0] sram_readdata;
  logic        out_valid, out_ready, out_last, busy, done;
  logic [15:0] out_data;
`ifdef NPU_STREAM_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  logic [15:0] mem [0:4095];
  logic [11:0] addr_log [$];
  int checks = 0;
  int errors = 0;
  int first_valid, done_cyc, done_cnt, n_cs, n_acc, max_out;
  logic done_seen;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_chipselect && sram_clken && !sram_write) sram_readdata <= mem[sram_address];
  end

  npu_sram_stream_reader dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_base        (cmd_base),
    .cmd_len         (cmd_len),
    .abort           (abort),
    .sram_address    (sram_address),
    .sram_chipselect (sram_chipselect),
    .sram_write      (sram_write),
    .sram_byteenable (sram_byteenable),
    .sram_clken      (sram_clken),
    .sram_readdata   (sram_readdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_last        (out_last),
    .busy            (busy),
    .done            (done)
`ifdef NPU_STREAM_CHECKSUM_EN
    ,
    .checksum        (checksum)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and watch the stream until done (or until abort fires).
  task automatic run_cmd(input logic [11:0] base, input logic [12:0] len, input bit stall,
                         input int abort_after, input logic [15:0] exp_sum);
    logic        prev_stall, prev_last;
    logic [15:0] prev_data;
    logic [11:0] ea;
    int          c;
    addr_log.delete();
    first_valid = -1; done_cyc = -1; done_cnt = 0; n_cs = 0; n_acc = 0; max_out = 0;
    done_seen = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
    chk("pre_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_base = base; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (c = 1; c < 300; c++) begin
      out_ready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      if (abort_after >= 0 && n_acc == abort_after) begin
        abort = 1'b1; out_ready = 1'b0;
        #1;
        chk("abort_cs_low", sram_chipselect, 0);
        @(negedge clk);
        abort = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_idle", busy, 0);
        chk("abort_no_done", {done_cnt[30:0], done}, 0);
        done_seen = 1'b1;
        break;
      end
      #1;
      if (n_cs - n_acc > max_out) max_out = n_cs - n_acc;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      if (sram_chipselect) begin
        addr_log.push_back(sram_address);
        n_cs++;
      end
      if (out_valid && first_valid < 0) first_valid = c;
      if (out_valid && out_ready) begin
        ea = base + 12'(n_acc);
        chk("word_data", out_data, mem[ea]);
        chk("word_last", out_last, (n_acc == int'(len) - 1));
        n_acc++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (done) begin
        done_cnt++;
        done_cyc = c;
`ifdef NPU_STREAM_CHECKSUM_EN
        chk("checksum_at_done", checksum, exp_sum);
`endif
      end
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        chk("cmd_ready_after_done", cmd_ready, 1);
        done_seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("cmd_finished_in_budget", done_seen, 1);
    chk("max_outstanding_le_depth", (max_out <= 4), 1);
    if (abort_after < 0) begin
      chk("accepted_count", n_acc, len);
      chk("done_once", done_cnt, 1);
      chk("issue_count", n_cs, len);
    end
    if (exp_sum == 16'hDEAD) $display("note: unused checksum sentinel");
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i * 7 + 16'h0300);
    mem[12'h010] = 16'h1111; mem[12'h011] = 16'h2222;
    mem[12'h012] = 16'h3333; mem[12'h013] = 16'h4444;
    mem[12'hFFE] = 16'hA0FE; mem[12'hFFF] = 16'hA0FF;
    mem[12'h000] = 16'hA000; mem[12'h001] = 16'hA001;
    mem[12'h200] = 16'hFFFF; mem[12'h201] = 16'h0002; mem[12'h202] = 16'h0010;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0;
    abort = 1'b0; out_ready = 1'b1; sram_readdata = '0;

    #3;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cs", sram_chipselect, 0);
    chk("rst_addr", sram_address, 0);
    chk("const_write", sram_write, 0);
    chk("const_be", sram_byteenable, 2'b11);
    chk("const_clken", sram_clken, 1);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("cmd_ready_before_first_clk", cmd_ready, 0);
    @(negedge clk);

    // Basic 4-word fetch at full throughput.
    run_cmd(12'h010, 13'd4, 1'b0, -1, 16'h0000);
    chk("first_valid_latency", first_valid, 3);
    chk("done_cycle", done_cyc, 7);
    chk("addr0", addr_log[0], 12'h010);
    chk("addr3", addr_log[3], 12'h013);
    @(negedge clk);

    // Address wrap at the top of the buffer.
    run_cmd(12'hFFE, 13'd4, 1'b0, -1, 16'h0000);
    chk("wrap_addr0", addr_log[0], 12'hFFE);
    chk("wrap_addr1", addr_log[1], 12'hFFF);
    chk("wrap_addr2", addr_log[2], 12'h000);
    chk("wrap_addr3", addr_log[3], 12'h001);
    @(negedge clk);

    // Backpressure: out_ready toggled 1-0-0-1.
    run_cmd(12'h040, 13'd8, 1'b1, -1, 16'h0000);
    @(negedge clk);

    // Zero-length command.
    run_cmd(12'h080, 13'd0, 1'b0, -1, 16'h0000);
    chk("zero_len_done_cycle", done_cyc, 1);
    @(negedge clk);

    // Abort mid-command, then a normal follow-up.
    run_cmd(12'h020, 13'd16, 1'b0, 5, 16'h0000);
    chk("abort_after_5", n_acc, 5);
    @(negedge clk);
    run_cmd(12'h100, 13'd2, 1'b0, -1, 16'h0000);
    @(negedge clk);

`ifdef NPU_STREAM_CHECKSUM_EN
    run_cmd(12'h200, 13'd3, 1'b0, -1, 16'h0011);
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
